// File: rtl/addatone_pkg.sv
// Shared definitions for the additive oscillator: sequencer state encoding and default widths.
package addatone_pkg;

    localparam int DIV_BIT   = 8;
    localparam int FREQ_BIT  = 32;
    localparam int HARMONICS = 64;
    localparam int HARM_BIT  = 6;

    typedef enum logic [1:0] {
        IDLE,
        RESTART,
        ISSUE,
        DONE
    } state_t;

endpackage

// File: rtl/harmonic_sequencer_scale_mult.sv
// scale_mult: one amplitude channel; reloads on restart, saturating-subtracts its scale on each start.
module scale_mult #(
    parameter int DIV_BIT = addatone_pkg::DIV_BIT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               restart,
    input  logic               start,
    input  logic [DIV_BIT-1:0] init,
    input  logic [DIV_BIT-1:0] scale,
    output logic [DIV_BIT-1:0] mult
);

    always_ff @(posedge clock) begin
        if (reset) begin
            mult <= '0;
        end else if (restart) begin
            mult <= init;
        end else if (start) begin
            mult <= (mult > scale) ? mult - scale : '0;
        end
    end

endmodule

// File: rtl/harmonic_sequencer.sv
// Per-sample frame controller: issues harmonics 0..HARMONICS-1 with phase increment and amplitude.
// Optional build macro HARM_COUNT_EN adds o_count, the harmonics accepted in the last completed frame.
module harmonic_sequencer #(
    parameter int DIV_BIT   = addatone_pkg::DIV_BIT,
    parameter int FREQ_BIT  = addatone_pkg::FREQ_BIT,
    parameter int HARMONICS = addatone_pkg::HARMONICS,
    parameter int HARM_BIT  = addatone_pkg::HARM_BIT
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_sample_tick,
    input  logic [FREQ_BIT-1:0] i_freq,
    input  logic [FREQ_BIT-1:0] i_nyquist,
    input  logic [DIV_BIT-1:0]  i_initial,
    input  logic [DIV_BIT-1:0]  i_scale_odd,
    input  logic [DIV_BIT-1:0]  i_scale_even,
    input  logic                i_ready,
    output logic                o_valid,
    output logic [HARM_BIT-1:0] o_harmonic,
    output logic [FREQ_BIT-1:0] o_freq,
    output logic [DIV_BIT-1:0]  o_mult,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_overrun
`ifdef HARM_COUNT_EN
    ,
    output logic [HARM_BIT:0]   o_count
`endif
);
    import addatone_pkg::*;

    state_t              state;
    logic [FREQ_BIT-1:0] freq_q;
    logic [FREQ_BIT-1:0] nyq_q;
    logic [FREQ_BIT-1:0] acc;
    logic [DIV_BIT-1:0]  scale_odd_q;
    logic [DIV_BIT-1:0]  scale_even_q;
    logic [HARM_BIT-1:0] h;
    logic                restart_ch;
    logic                accept;
    logic                start_odd;
    logic                start_even;
    logic [DIV_BIT-1:0]  odd_mult;
    logic [DIV_BIT-1:0]  even_mult;
    logic [DIV_BIT-1:0]  odd_post;
    logic [DIV_BIT-1:0]  even_post;
    logic [FREQ_BIT:0]   next_sum;
    logic                last;
`ifdef HARM_COUNT_EN
    logic [HARM_BIT:0]   cnt;
`endif

    assign restart_ch = (state == RESTART);
    assign accept     = (state == ISSUE) && o_valid && i_ready;
    assign start_odd  = accept && h[0];
    assign start_even = accept && !h[0];

    // Channels reload only while in RESTART, the same cycle the other inputs are captured,
    // so feeding i_initial directly is equivalent to using a latched copy.
    scale_mult #(.DIV_BIT(DIV_BIT)) u_odd (
        .clock   (i_clock),
        .reset   (i_reset),
        .restart (restart_ch),
        .start   (start_odd),
        .init    (i_initial),
        .scale   (scale_odd_q),
        .mult    (odd_mult)
    );

    scale_mult #(.DIV_BIT(DIV_BIT)) u_even (
        .clock   (i_clock),
        .reset   (i_reset),
        .restart (restart_ch),
        .start   (start_even),
        .init    (i_initial),
        .scale   (scale_even_q),
        .mult    (even_mult)
    );

    // Mirror the channel step combinationally so the zero-amplitude exit is decided on acceptance.
    assign odd_post  = start_odd  ? ((odd_mult  > scale_odd_q)  ? odd_mult  - scale_odd_q  : '0) : odd_mult;
    assign even_post = start_even ? ((even_mult > scale_even_q) ? even_mult - scale_even_q : '0) : even_mult;
    assign next_sum  = {1'b0, acc} + {1'b0, freq_q};
    assign last      = (h == HARM_BIT'(HARMONICS - 1))
                    || next_sum[FREQ_BIT]
                    || (next_sum[FREQ_BIT-1:0] > nyq_q)
                    || ((odd_post == '0) && (even_post == '0));

    assign o_harmonic = h;
    assign o_freq     = acc;
    assign o_mult     = h[0] ? odd_mult : even_mult;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state        <= IDLE;
            freq_q       <= '0;
            nyq_q        <= '0;
            acc          <= '0;
            scale_odd_q  <= '0;
            scale_even_q <= '0;
            h            <= '0;
            o_valid      <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_overrun    <= 1'b0;
`ifdef HARM_COUNT_EN
            cnt          <= '0;
            o_count      <= '0;
`endif
        end else begin
            if (i_sample_tick && (state != IDLE)) begin
                o_overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (i_sample_tick) begin
                        state  <= RESTART;
                        o_busy <= 1'b1;
                    end
                end
                RESTART: begin
                    freq_q       <= i_freq;
                    nyq_q        <= i_nyquist;
                    scale_odd_q  <= i_scale_odd;
                    scale_even_q <= i_scale_even;
                    acc          <= i_freq;
                    h            <= '0;
                    o_valid      <= 1'b1;
                    state        <= ISSUE;
`ifdef HARM_COUNT_EN
                    cnt          <= '0;
`endif
                end
                ISSUE: begin
                    if (accept) begin
`ifdef HARM_COUNT_EN
                        cnt <= cnt + 1'b1;
`endif
                        if (last) begin
                            state   <= DONE;
                            o_valid <= 1'b0;
                            o_done  <= 1'b1;
`ifdef HARM_COUNT_EN
                            o_count <= cnt + 1'b1;
`endif
                        end else begin
                            h   <= h + 1'b1;
                            acc <= next_sum[FREQ_BIT-1:0];
                        end
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
